// File: rtl/mem_bank_cfg_pkg.sv
// Shared types and default timing for the memory-bank config controllers.
package mem_bank_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 1;

endpackage

// File: rtl/mem_bank_wl_decoder.sv
// Row address to one-hot word-line decode with enable and out-of-range flag.
module mem_bank_wl_decoder #(
  parameter int WL_WIDTH   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [0:WL_WIDTH-1]   wl,
  output logic                  out_of_range
);

  always_comb begin
    out_of_range = (int'(addr) >= WL_WIDTH);
    for (int i = 0; i < WL_WIDTH; i++) begin
      wl[i] = en && (addr == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/mem_bank_cfg_ctrl.sv
// Config-word sequencer for one tile column: drives bl, then a timed one-hot
// wl strobe, then a hold phase before releasing bl.
//
// state  | meaning
// IDLE   | waiting for a config word; bl and wl low
// SETUP  | bl driven, wl low, counting setup time
// STROBE | bl driven, wl[addr] high, counting pulse width
// HOLD   | bl still driven, wl low, counting hold time
module mem_bank_cfg_ctrl
  import mem_bank_cfg_pkg::*;
#(
  parameter int BL_WIDTH     = 8,
  parameter int WL_WIDTH     = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [BL_WIDTH-1:0]   cfg_bl_data,
  input  logic [ADDR_WIDTH-1:0] cfg_wl_addr,
  input  logic                  cfg_last,
  output logic [0:BL_WIDTH-1]   bl,
  output logic [0:WL_WIDTH-1]   wl,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [15:0]           word_count
);

  localparam logic [CNT_WIDTH-1:0] SETUP_LD = CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LD = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LD  = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [0:BL_WIDTH-1]   bl_q, bl_n;
  logic [0:WL_WIDTH-1]   wl_q, wl_n, dec_wl;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n, dec_addr;
  logic                  last_q, last_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic [15:0]           words_q, words_n;
  logic                  accept, dec_oor, cnt_tc;

  assign cfg_ready  = ~pReset & (state == IDLE) & cfg_enable & ~done_q;
  assign accept     = cfg_valid & cfg_ready;
  assign cnt_tc     = (cnt == '0);
  // In IDLE the decoder range-checks the incoming address; afterwards it decodes the latched row.
  assign dec_addr   = (state == IDLE) ? cfg_wl_addr : addr_q;

  assign bl         = bl_q;
  assign wl         = wl_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign word_count = words_q;

  mem_bank_wl_decoder #(
    .WL_WIDTH   (WL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wl_dec (
    .en           (state == SETUP),
    .addr         (dec_addr),
    .wl           (dec_wl),
    .out_of_range (dec_oor)
  );

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state   <= IDLE;
      cnt     <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bl_q    <= bl_n;
      wl_q    <= wl_n;
      addr_q  <= addr_n;
      last_q  <= last_n;
      done_q  <= done_n;
      err_q   <= err_n;
      words_q <= words_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bl_n    = bl_q;
    wl_n    = wl_q;
    addr_n  = addr_q;
    last_n  = last_q;
    done_n  = done_q;
    err_n   = err_q;
    words_n = words_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_oor) begin
            // Dropped word: bus untouched, but a final word still ends the stream.
            err_n = 1'b1;
            if (cfg_last) done_n = 1'b1;
          end else begin
            state_n = SETUP;
            cnt_n   = SETUP_LD;
            addr_n  = cfg_wl_addr;
            last_n  = cfg_last;
            for (int i = 0; i < BL_WIDTH; i++) bl_n[i] = cfg_bl_data[i];
          end
        end
      end
      SETUP: begin
        if (cnt_tc) begin
          state_n = STROBE;
          wl_n    = dec_wl;
          cnt_n   = PULSE_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_tc) begin
          state_n = HOLD;
          wl_n    = '0;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_tc) begin
          state_n = IDLE;
          bl_n    = '0;
          if (words_q != 16'hFFFF) words_n = words_q + 16'd1;
          if (last_q) done_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bank_cfg_ctrl.sv
// Directed bench for mem_bank_cfg_ctrl with a strobe scoreboard and bus-invariant monitor.
module tb_mem_bank_cfg_ctrl;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        cfg_enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_bl_data;
  logic [3:0]  cfg_wl_addr;
  logic        cfg_last;
  logic [0:7]  bl;
  logic [0:7]  wl;
  logic        cfg_done;
  logic        cfg_err;
  logic [15:0] word_count;

  int n_assert = 0;
  int n_fail   = 0;

  // each entry: {expected wl bus, expected bl bus} as seen MSB = index 0
  logic [15:0] sb[$];

  always #5 prog_clk = ~prog_clk;

  mem_bank_cfg_ctrl #(
    .BL_WIDTH   (8),
    .WL_WIDTH   (8),
    .ADDR_WIDTH (4),
    .CNT_WIDTH  (4)
  ) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .cfg_enable  (cfg_enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_bl_data (cfg_bl_data),
    .cfg_wl_addr (cfg_wl_addr),
    .cfg_last    (cfg_last),
    .bl          (bl),
    .wl          (wl),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .word_count  (word_count)
  );

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = d[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic [3:0] a, input logic l);
    int n;
    n = 0;
    @(negedge prog_clk);
    while (!cfg_ready && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    chk("ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_valid   = 1'b1;
    cfg_bl_data = d;
    cfg_wl_addr = a;
    cfg_last    = l;
    if (a < 4'd8) sb.push_back({8'h80 >> a, rev8(d)});
    @(posedge prog_clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] target);
    int n;
    n = 0;
    while (word_count !== target && n < 60) begin
      @(negedge prog_clk);
      n++;
    end
    chk("word_count", {16'd0, word_count}, {16'd0, target});
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    @(negedge prog_clk);
    while (wl === 8'h00 && n < 60) begin
      @(negedge prog_clk);
      n++;
    end
    chk("strobe_seen", {31'd0, (wl !== 8'h00)}, 32'd1);
  endtask

  // Monitor: one-hot wl, bl stable around strobes, scoreboard on each pulse rise.
  logic [7:0]  prev_wl, prev_bl;
  logic [15:0] exp_e;
  bit          prev_ok  = 0;
  bit          in_pulse = 0;
  int          width    = 0;

  always @(negedge prog_clk or posedge pReset) begin
    if (pReset) begin
      prev_ok  = 0;
      in_pulse = 0;
    end else begin
      chk("wl_onehot0", {31'd0, $onehot0(wl)}, 32'd1);
      if (prev_ok) begin
        if (prev_wl != 8'h00 && wl != 8'h00) chk("bl_stable_in_strobe", {24'd0, bl}, {24'd0, prev_bl});
        if (bl !== prev_bl) chk("bl_edge_wl_low", {24'd0, prev_wl | wl}, 32'd0);
      end
      if (wl != 8'h00 && !in_pulse) begin
        in_pulse = 1;
        width    = 1;
        chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          exp_e = sb.pop_front();
          chk("sb_wl", {24'd0, wl}, {24'd0, exp_e[15:8]});
          chk("sb_bl", {24'd0, bl}, {24'd0, exp_e[7:0]});
        end
      end else if (wl != 8'h00) begin
        width++;
      end else if (in_pulse) begin
        in_pulse = 0;
        chk("pulse_width", width, 32'd2);
      end
      prev_wl = wl;
      prev_bl = bl;
      prev_ok = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pReset      = 1'b1;
    cfg_enable  = 1'b0;
    cfg_valid   = 1'b0;
    cfg_bl_data = '0;
    cfg_wl_addr = '0;
    cfg_last    = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("rst_bl", {24'd0, bl}, 32'd0);
    chk("rst_wl", {24'd0, wl}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_count", {16'd0, word_count}, 32'd0);
    pReset     = 1'b0;
    cfg_enable = 1'b1;

    // single word: exact cycle timing
    send_word(8'hA5, 4'd3, 1'b0);
    @(negedge prog_clk);
    chk("t1_c1_bl", {24'd0, bl}, 32'hA5);
    chk("t1_c1_wl", {24'd0, wl}, 32'h00);
    @(negedge prog_clk);
    chk("t1_c2_wl", {24'd0, wl}, 32'h10);
    @(negedge prog_clk);
    chk("t1_c3_wl", {24'd0, wl}, 32'h10);
    chk("t1_c3_bl", {24'd0, bl}, 32'hA5);
    @(negedge prog_clk);
    chk("t1_c4_wl", {24'd0, wl}, 32'h00);
    chk("t1_c4_bl", {24'd0, bl}, 32'hA5);
    chk("t1_c4_ready", {31'd0, cfg_ready}, 32'd0);
    @(negedge prog_clk);
    chk("t1_c5_bl", {24'd0, bl}, 32'h00);
    chk("t1_c5_count", {16'd0, word_count}, 32'd1);
    chk("t1_c5_ready", {31'd0, cfg_ready}, 32'd1);

    // out-of-range row is dropped, next word still written
    send_word(8'h3C, 4'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      chk("oor_err", {31'd0, cfg_err}, 32'd1);
      chk("oor_wl", {24'd0, wl}, 32'd0);
      chk("oor_bl", {24'd0, bl}, 32'd0);
      chk("oor_count", {16'd0, word_count}, 32'd1);
    end
    send_word(8'h81, 4'd2, 1'b0);
    wait_count(16'd2);

    // enable dropped mid-strobe: word completes, no new acceptance
    send_word(8'h5A, 4'd6, 1'b0);
    wait_strobe();
    cfg_enable = 1'b0;
    wait_count(16'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      chk("en_low_ready", {31'd0, cfg_ready}, 32'd0);
    end
    cfg_enable = 1'b1;
    #1 chk("en_back_ready", {31'd0, cfg_ready}, 32'd1);

    // eight back-to-back rows, last on row 7
    for (int i = 0; i < 8; i++) begin
      send_word(8'(8'h1D * (i + 1)), 4'(i), (i == 7));
    end
    wait_count(16'd11);
    chk("b2b_done", {31'd0, cfg_done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      chk("done_ready_low", {31'd0, cfg_ready}, 32'd0);
    end
    chk("b2b_sb_empty", sb.size(), 32'd0);

    // clean reset, then async reset in the middle of a strobe
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    chk("rst2_done", {31'd0, cfg_done}, 32'd0);
    chk("rst2_count", {16'd0, word_count}, 32'd0);
    send_word(8'hFF, 4'd8, 1'b0);
    @(negedge prog_clk);
    chk("oor8_err", {31'd0, cfg_err}, 32'd1);
    send_word(8'h0F, 4'd5, 1'b0);
    wait_strobe();
    chk("mid_wl_high", {24'd0, wl}, 32'h04);
    #2 pReset = 1'b1;
    #1;
    chk("arst_wl", {24'd0, wl}, 32'd0);
    chk("arst_bl", {24'd0, bl}, 32'd0);
    chk("arst_err", {31'd0, cfg_err}, 32'd0);
    chk("arst_done", {31'd0, cfg_done}, 32'd0);
    chk("arst_count", {16'd0, word_count}, 32'd0);
    #1 pReset = 1'b0;
    @(negedge prog_clk);
    chk("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bank_cfg_ctrl.md
Name: mem_bank_cfg_ctrl

Overview:
Sequences configuration writes into memory-bank-addressed config cells of grid tiles such as IO columns, which take bl (bit-line) and wl (word-line) vectors. The block accepts one config word per handshake: a BL data vector plus a WL row address. It drives the BL vector, then a timed one-hot WL strobe, then a hold phase. It sits between the bitstream loader and the bl/wl buses of one tile column.

Parameters:
BL_WIDTH, 8, number of bit-lines driven (bl bus width)
WL_WIDTH, 8, number of word-lines driven (wl bus width)
ADDR_WIDTH, 3, width of the WL row address; must satisfy 2**ADDR_WIDTH >= WL_WIDTH
SETUP_CYCLES, 1, cycles bl is stable before the wl strobe (>=1)
PULSE_CYCLES, 2, cycles the wl strobe is held high (>=1)
HOLD_CYCLES, 1, cycles bl is held after the wl strobe falls (>=1)
CNT_WIDTH, 4, width of the phase counter; must hold max(SETUP,PULSE,HOLD)

Ports:
prog_clk  input  1  programming clock; all state on the rising edge
pReset  input  1  asynchronous, active-high reset
cfg_enable  input  1  controller enable; when low, no new word is accepted
cfg_valid  input  1  config word valid
cfg_ready  output  1  controller can accept a word
cfg_bl_data  input  BL_WIDTH  bit-line values for the addressed row
cfg_wl_addr  input  ADDR_WIDTH  target word-line index
cfg_last  input  1  marks the final word of the bitstream
bl  output  [0:BL_WIDTH-1]  bit-line bus to tiles; bl[0] = cfg_bl_data[0]
wl  output  [0:WL_WIDTH-1]  word-line bus to tiles; at most one bit high
cfg_done  output  1  sticky; set when the last word completes
cfg_err  output  1  sticky; out-of-range address received
word_count  output  16  number of words written to cells (saturating)

Behaviour:
- Clock and reset: one clock, prog_clk. Reset pReset is asynchronous and active-high. Reset values: state=IDLE; bl=0; wl=0; cfg_ready=0; cfg_done=0; cfg_err=0; word_count=0; counter=0.
- Ready rule: cfg_ready = (state==IDLE) & cfg_enable & ~cfg_done. It is a registered-state decode, not combinational from cfg_valid.
- Acceptance: a word is accepted when cfg_valid & cfg_ready at a rising edge. Accepting latches bl_data, addr and last.
- FSM states and transitions:
  - IDLE: on accept with addr < WL_WIDTH, go to SETUP. bl takes the latched data in the same edge. counter=SETUP_CYCLES-1.
  - IDLE: on accept with addr >= WL_WIDTH, set cfg_err and stay in IDLE. bl and wl are untouched; the word is dropped and word_count is unchanged. If last was set, cfg_done is still set.
  - SETUP: decrement counter. At 0, go to STROBE, set wl[addr]=1 and counter=PULSE_CYCLES-1.
  - STROBE: wl[addr] stays high. At counter 0, clear wl, go to HOLD, counter=HOLD_CYCLES-1.
  - HOLD: bl stays stable. At counter 0, go to IDLE, clear bl to 0 and increment word_count (saturating at 0xFFFF). If the latched last=1, set cfg_done.
- Timing: bl is valid for SETUP+PULSE+HOLD cycles. wl is high exactly PULSE_CYCLES cycles. With defaults, a word occupies 4 cycles plus 1 IDLE cycle, so back-to-back throughput is one word per 5 cycles.
- wl is never high while bl is changing. A wl rising or falling edge never coincides with a bl transition.
- cfg_enable deasserted mid-word: the current word completes normally (no truncated strobe). Only new acceptance is blocked.
- cfg_done is cleared only by pReset. Once set, cfg_ready stays low.
- pReset asserted mid-STROBE: wl and bl drop to 0 immediately (asynchronous).
- cfg_valid while cfg_ready=0: ignored; the upstream holds the data.

Decomposition:
- Package mem_bank_cfg_pkg: FSM state enum (IDLE, SETUP, STROBE, HOLD) and the default timing constants.
- Sub-module mem_bank_wl_decoder: combinational addr-to-one-hot decode with an enable and an out-of-range flag. Reused by the other grid column controllers.

Test Plan:
- Reset release, enable=1, valid=1, addr=3, data=8'hA5, last=0:
  - bl=A5 from cycle 1 to 4.
  - wl=8'b00010000 (wl[3]) on cycles 2-3.
  - bl=0 on cycle 5; word_count=1; cfg_ready returns high.
- 8 back-to-back words, addr 0..7, last on addr 7:
  - 8 single-bit wl pulses in order.
  - word_count=8; cfg_done=1; cfg_ready stays 0 afterwards.
- addr=9 with ADDR_WIDTH=4, WL_WIDTH=8:
  - cfg_err=1; wl stays 0; bl stays 0; word_count unchanged.
  - The next valid word (addr=2) is still written.
- cfg_enable dropped during STROBE:
  - The pulse is still 2 cycles wide and the word completes.
  - cfg_ready stays 0 until enable returns.
- pReset pulsed during STROBE:
  - wl=0 and bl=0 within the same cycle with no clock edge needed; all flags cleared.
- Assertion, run across all tests: wl is one-hot or zero at all times, and bl never changes while |wl is high.
